rename_sched: RTL
=================

Name: rename_sched

Overview:
Sequencing controller in front of the register-rename stage.
- Buffers decoded instructions in a small issue queue and presents one per cycle to rename. Issue is gated by a shadow free-register count, so rename never runs out of physical registers.
- Accepts up to two ROB retire releases per cycle and serialises them onto rename's single retire port through a release queue.

Parameters:
- NUM_PHYS_REGS, 64, physical register count (6-bit tags).
- NUM_ARCH_REGS, 32, architectural registers; initial free count = NUM_PHYS_REGS - NUM_ARCH_REGS.
- IQ_DEPTH, 4, issue queue entries (power of 2).
- RQ_DEPTH, 8, release queue entries (power of 2).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- dec_valid  in  1  decode offers an instruction.
- dec_ready  out  1  issue queue can accept.
- dec_rs1, dec_rs2, dec_rd  in  5 each  architectural register fields.
- ren_issue_valid  out  1  issue strobe to rename.
- ren_rs1, ren_rs2, ren_rd  out  5 each  head-entry fields.
- ren_free_list_empty  in  1  rename's empty flag.
- rob_ret0_valid, rob_ret1_valid  in  1 each  retire release requests; ret0 has priority.
- rob_ret0_preg, rob_ret1_preg  in  6 each  physical tags being freed.
- ren_retire_valid  out  1  release strobe to rename.
- ren_retire_phys_reg  out  6  released tag.
- free_count  out  7  shadow free-register count.
- iq_count  out  3  issue queue occupancy.
- stall  out  1  FSM is in STALL.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset_n low at posedge):
  - Both queues empty; free_count = 32; FSM = RUN; err = 0.
  - Combinational outputs follow: dec_ready = 1, ren_issue_valid = 0, ren_retire_valid = 0.
  - Reset mid-operation discards all queued entries; no release is emitted.
- Issue queue:
  - Enqueue at posedge when dec_valid && dec_ready.
  - dec_ready = (iq_count != IQ_DEPTH), from registered state only. When full there is no same-cycle enqueue/dequeue pass-through.
- Issue:
  - ren_issue_valid = (iq_count != 0) && (free_count != 0) && state == RUN. This is combinational from registered state.
  - ren_rs1/rs2/rd always show the head entry.
  - The head pops at the posedge where ren_issue_valid = 1.
- FSM:
  - RUN -> STALL when the next free_count = 0.
  - STALL -> RUN when the next free_count > 0.
  - stall = (state == STALL). No issue occurs in STALL; the queue keeps accepting until full.
- Release queue:
  - Per cycle it enqueues ret0 then ret1, as valid, in that order.
  - If only one slot is free, ret0 is kept, ret1 is dropped, and err is set. If no slot is free, both are dropped and err is set.
  - ren_retire_valid = (rq_count != 0); the head pops every cycle it is valid.
  - No bypass: a release reaches rename at the earliest one cycle after arrival.
- free_count:
  - Decrements on an issue and increments on a release pop; both in the same cycle leave it unchanged.
  - An increment past NUM_PHYS_REGS saturates and sets err.
- err is also set if ren_free_list_empty = 1 while ren_issue_valid = 1. Once set, err clears only on reset.
- Tag 63 needs no special handling; it is released like any other tag.

Optional Feature:
- Macro RENAME_SCHED_PERF_EN.
- Defined: adds output stall_cycles (16 bits). It counts cycles where iq_count != 0 && state == STALL, saturates at 0xFFFF, and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 instructions offered back-to-back (rd = 1..4) -> issued on 4 consecutive cycles in order; free_count 32 -> 28; iq_count returns to 0.
- Hold dec_valid for 40 instructions with no retires -> exactly 32 issues, then stall = 1, ren_issue_valid = 0, iq_count = 4, dec_ready = 0.
- From that stalled state, one ret0 of preg 40 -> ren_retire_valid with tag 40 one cycle later; free_count becomes 1 at that edge; FSM returns to RUN; one issue follows, then stall again.
- ret0 = 33 and ret1 = 34 in the same cycle, with the release queue empty -> releases 33 then 34 on consecutive cycles; free_count +2.
- Release queue at 7/8 with ret0 and ret1 both valid -> ret0 queued, ret1 dropped, err = 1 and stays set.
- Issue and release in the same cycle at free_count = 5 -> free_count stays 5.

Source files
------------

// File: rtl/rename_sched.sv
// Rename-stage sequencer: an issue queue gated by a shadow free-register count, and a release queue feeding rename's retire port.
// Optional macro RENAME_SCHED_PERF_EN adds the stall_cycles counter output.
module rename_sched #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int IQ_DEPTH      = 4,
    parameter int RQ_DEPTH      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,
    output logic       ren_issue_valid,
    output logic [4:0] ren_rs1,
    output logic [4:0] ren_rs2,
    output logic [4:0] ren_rd,
    input  logic       ren_free_list_empty,
    input  logic       rob_ret0_valid,
    input  logic       rob_ret1_valid,
    input  logic [5:0] rob_ret0_preg,
    input  logic [5:0] rob_ret1_preg,
    output logic       ren_retire_valid,
    output logic [5:0] ren_retire_phys_reg,
    output logic [6:0] free_count,
    output logic [2:0] iq_count,
    output logic       stall,
    output logic       err
`ifdef RENAME_SCHED_PERF_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam int IQ_AW = $clog2(IQ_DEPTH);
    localparam int RQ_AW = $clog2(RQ_DEPTH);

    typedef logic [IQ_AW-1:0] iq_ptr_t;
    typedef logic [RQ_AW-1:0] rq_ptr_t;
    typedef logic [RQ_AW:0]   rq_cnt_t;

    localparam logic [2:0] IQ_FULL   = 3'(IQ_DEPTH);
    localparam rq_cnt_t    RQ_FULL   = rq_cnt_t'(RQ_DEPTH);
    localparam logic [6:0] FREE_MAX  = 7'(NUM_PHYS_REGS);
    localparam logic [6:0] FREE_INIT = 7'(NUM_PHYS_REGS - NUM_ARCH_REGS);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
    state_t state;

    logic [4:0] iq_rs1 [IQ_DEPTH];
    logic [4:0] iq_rs2 [IQ_DEPTH];
    logic [4:0] iq_rd  [IQ_DEPTH];
    iq_ptr_t    iq_head, iq_tail;

    logic [5:0] rq_tag [RQ_DEPTH];
    rq_ptr_t    rq_head, rq_tail;
    rq_cnt_t    rq_count, rq_room;

    logic       iq_push, iq_pop, rq_pop;
    logic       wr_a_en, wr_b_en, rq_drop, fc_sat;
    logic [5:0] wr_a_tag;
    logic [1:0] rq_push_n;
    logic [6:0] fc_next;

    assign dec_ready           = (iq_count != IQ_FULL);
    assign ren_issue_valid     = (iq_count != '0) && (free_count != '0) && (state == RUN);
    assign ren_retire_valid    = (rq_count != '0);
    assign stall               = (state == STALL);
    assign ren_rs1             = iq_rs1[iq_head];
    assign ren_rs2             = iq_rs2[iq_head];
    assign ren_rd              = iq_rd[iq_head];
    assign ren_retire_phys_reg = rq_tag[rq_head];

    assign iq_push = dec_valid && dec_ready;
    assign iq_pop  = ren_issue_valid;
    assign rq_pop  = ren_retire_valid;

    // Room is judged on registered occupancy only, so a same-cycle pop never makes space for a release.
    always_comb begin
        rq_room  = RQ_FULL - rq_count;
        wr_a_en  = 1'b0;
        wr_b_en  = 1'b0;
        wr_a_tag = rob_ret0_preg;
        rq_drop  = 1'b0;
        if (rob_ret0_valid && rob_ret1_valid) begin
            wr_a_en = (rq_room != '0);
            wr_b_en = (rq_room > rq_cnt_t'(1));
            rq_drop = (rq_room < rq_cnt_t'(2));
        end else if (rob_ret0_valid) begin
            wr_a_en = (rq_room != '0);
            rq_drop = (rq_room == '0);
        end else if (rob_ret1_valid) begin
            wr_a_en  = (rq_room != '0);
            wr_a_tag = rob_ret1_preg;
            rq_drop  = (rq_room == '0);
        end
        rq_push_n = {1'b0, wr_a_en} + {1'b0, wr_b_en};
    end

    always_comb begin
        fc_next = free_count;
        fc_sat  = 1'b0;
        if (rq_pop && !iq_pop) begin
            if (free_count == FREE_MAX) begin
                fc_sat = 1'b1;
            end else begin
                fc_next = free_count + 7'd1;
            end
        end else if (!rq_pop && iq_pop) begin
            fc_next = free_count - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iq_head    <= '0;
            iq_tail    <= '0;
            iq_count   <= '0;
            rq_head    <= '0;
            rq_tail    <= '0;
            rq_count   <= '0;
            free_count <= FREE_INIT;
            state      <= RUN;
            err        <= 1'b0;
        end else begin
            if (iq_push) iq_tail <= iq_tail + iq_ptr_t'(1);
            if (iq_pop)  iq_head <= iq_head + iq_ptr_t'(1);
            iq_count <= iq_count + {2'b0, iq_push} - {2'b0, iq_pop};

            rq_tail  <= rq_tail + rq_ptr_t'(rq_push_n);
            if (rq_pop) rq_head <= rq_head + rq_ptr_t'(1);
            rq_count <= rq_count + rq_cnt_t'(rq_push_n) - rq_cnt_t'(rq_pop);

            free_count <= fc_next;
            case (state)
                RUN:     if (fc_next == '0) state <= STALL;
                STALL:   if (fc_next != '0) state <= RUN;
                default: state <= RUN;
            endcase

            if (rq_drop || fc_sat || (ren_free_list_empty && ren_issue_valid)) err <= 1'b1;
        end
    end

    // Queue payloads need no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && iq_push) begin
            iq_rs1[iq_tail] <= dec_rs1;
            iq_rs2[iq_tail] <= dec_rs2;
            iq_rd[iq_tail]  <= dec_rd;
        end
        if (reset_n && wr_a_en) rq_tag[rq_tail] <= wr_a_tag;
        if (reset_n && wr_b_en) rq_tag[rq_tail + rq_ptr_t'(1)] <= rob_ret1_preg;
    end

`ifdef RENAME_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if ((iq_count != '0) && (state == STALL) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
